iter_divider: RTL and testbench

- Multi-cycle 32-bit integer divider for the RV32M execute stage: DIV, DIVU, REM, REMU.
- It is the inverse-direction counterpart of the carry-select adder path. Each iteration does one trial subtraction, and the sign of that result selects restore or keep.
- It sits beside the ALU. The execute stage hands it operands with a valid/ready handshake and stalls until out_valid.

---
 rtl/iter_divider_pkg.sv | 40 ++++
 rtl/iter_divider_if.sv | 14 +
 rtl/iter_divider_trial_sub.sv | 32 +++
 rtl/iter_divider.sv | 157 +++++++++++++++
 tb/tb_iter_divider.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/iter_divider_pkg.sv
// Shared types, constants and helpers for the iterative RV32M divider.
package div_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_CNT_W = 6;

  typedef enum logic [1:0] {
    OP_DIV  = 2'd0,
    OP_DIVU = 2'd1,
    OP_REM  = 2'd2,
    OP_REMU = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [DIV_WIDTH-1:0] ALL_ONES = 32'hFFFF_FFFF;
  localparam logic [DIV_WIDTH-1:0] INT_MIN  = 32'h8000_0000;

  function automatic logic [DIV_WIDTH-1:0] cond_negate(input logic [DIV_WIDTH-1:0] value,
                                                       input logic neg);
    if (neg) begin
      cond_negate = ~value + DIV_WIDTH'(1);
    end else begin
      cond_negate = value;
    end
  endfunction

  function automatic logic is_signed_op(input op_e op);
    is_signed_op = (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic is_rem_op(input op_e op);
    is_rem_op = (op == OP_REM) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/iter_divider_if.sv
// Request/response bundle between the execute stage and the divider.
interface iter_divider_if #(parameter int WIDTH = 32);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             out_valid;
  logic [WIDTH-1:0] result;
  logic             busy;

  modport master (output in_valid, op, A, B, input in_ready, out_valid, result, busy);
  modport slave  (input in_valid, op, A, B, output in_ready, out_valid, result, busy);
endinterface

// File: rtl/iter_divider_trial_sub.sv
// Trial subtractor a - b, carry-select on 8-bit blocks; borrow=1 means a < b.
module div_trial_sub #(
  parameter int N = 33
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] diff,
  output logic         borrow
);
  localparam int BLK    = 8;
  localparam int NB     = (N + BLK - 1) / BLK;
  localparam int LAST_W = N - BLK * (NB - 1);

  logic [N-1:0] b_inv_s;
  logic [NB:0]  carry_s;

  assign b_inv_s    = ~b;
  assign carry_s[0] = 1'b1;

  // Both carry-in flavours per block are formed in parallel; the ripple only drives the muxes.
  for (genvar i = 0; i < NB; i++) begin : g_blk
    localparam int W = (i == NB - 1) ? LAST_W : BLK;
    logic [W:0] sum0_s;
    logic [W:0] sum1_s;
    assign sum0_s         = {1'b0, a[i*BLK +: W]} + {1'b0, b_inv_s[i*BLK +: W]};
    assign sum1_s         = {1'b0, a[i*BLK +: W]} + {1'b0, b_inv_s[i*BLK +: W]} + (W+1)'(1);
    assign carry_s[i+1]   = carry_s[i] ? sum1_s[W] : sum0_s[W];
    assign diff[i*BLK +: W] = carry_s[i] ? sum1_s[W-1:0] : sum0_s[W-1:0];
  end

  assign borrow = ~carry_s[NB];
endmodule

// File: rtl/iter_divider.sv
// Multi-cycle restoring divider for DIV/DIVU/REM/REMU, fixed 33-cycle latency
// for normal operands; divide-by-zero and signed overflow finish in one cycle.
module iter_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = DIV_CNT_W
) (
  input logic           clk,
  input logic           rst,
  iter_divider_if.slave bus
);
  state_e           state_r, next_state_s;
  op_e              op_s;
  logic [CNT_W-1:0] cnt_r;
  logic [WIDTH-1:0] rem_r, quo_r, bmag_r, result_r;
  logic             is_rem_r, neg_q_r, neg_r_r;
  logic             in_ready_r, busy_r, out_valid_r;
  logic             load_s, iter_s, last_s;
  logic             sgn_s, special_s;
  logic [WIDTH-1:0] a_mag_s, b_mag_s, special_val_s;
  logic [WIDTH:0]   shifted_s, diff_s, rem_full_s;
  logic             borrow_s, unused_rem_msb_s;
  logic [WIDTH-1:0] rem_next_s, quo_next_s, final_s;

  assign op_s = op_e'(bus.op);

  // Operand magnitudes and the single-cycle special-case results.
  always_comb begin
    sgn_s         = is_signed_op(op_s);
    a_mag_s       = cond_negate(bus.A, sgn_s & bus.A[WIDTH-1]);
    b_mag_s       = cond_negate(bus.B, sgn_s & bus.B[WIDTH-1]);
    special_s     = 1'b0;
    special_val_s = {WIDTH{1'b0}};
    if (bus.B == {WIDTH{1'b0}}) begin
      special_s     = 1'b1;
      special_val_s = is_rem_op(op_s) ? bus.A : ALL_ONES;
    end else if (sgn_s && (bus.A == INT_MIN) && (bus.B == ALL_ONES)) begin
      special_s     = 1'b1;
      special_val_s = is_rem_op(op_s) ? {WIDTH{1'b0}} : INT_MIN;
    end else begin
      special_s     = 1'b0;
      special_val_s = {WIDTH{1'b0}};
    end
  end

  // The dividend bit shifted out of quo_r enters the 33-bit partial remainder.
  assign shifted_s = {rem_r, quo_r[WIDTH-1]};

  div_trial_sub #(.N(WIDTH + 1)) u_trial_sub (
    .a      (shifted_s),
    .b      ({1'b0, bmag_r}),
    .diff   (diff_s),
    .borrow (borrow_s)
  );

  // Restore on borrow, otherwise keep the trial difference; sign-correct on the last step.
  always_comb begin
    rem_full_s       = borrow_s ? shifted_s : diff_s;
    rem_next_s       = rem_full_s[WIDTH-1:0];
    unused_rem_msb_s = rem_full_s[WIDTH];
    quo_next_s       = {quo_r[WIDTH-2:0], ~borrow_s};
    final_s          = is_rem_r ? cond_negate(rem_next_s, neg_r_r)
                                : cond_negate(quo_next_s, neg_q_r);
  end

  // FSM control strobes decoded from the current state.
  always_comb begin
    load_s = 1'b0;
    iter_s = 1'b0;
    last_s = 1'b0;
    case (state_r)
      S_IDLE: load_s = bus.in_valid;
      S_CALC: begin
        iter_s = 1'b1;
        last_s = (cnt_r == CNT_W'(WIDTH - 1));
      end
      S_DONE: load_s = 1'b0;
      default: load_s = 1'b0;
    endcase
  end

  // FSM next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (load_s) begin
          next_state_s = special_s ? S_DONE : S_CALC;
        end else begin
          next_state_s = S_IDLE;
        end
      end
      S_CALC: begin
        if (last_s) begin
          next_state_s = S_DONE;
        end else begin
          next_state_s = S_CALC;
        end
      end
      S_DONE:  next_state_s = S_IDLE;
      default: next_state_s = S_IDLE;
    endcase
  end

  // State register with handshake flags registered from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= S_IDLE;
      in_ready_r  <= 1'b1;
      busy_r      <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= next_state_s;
      in_ready_r  <= (next_state_s == S_IDLE);
      busy_r      <= (next_state_s != S_IDLE);
      out_valid_r <= (next_state_s == S_DONE);
    end
  end

  // Operand capture, iteration datapath and result register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r    <= {CNT_W{1'b0}};
      rem_r    <= {WIDTH{1'b0}};
      quo_r    <= {WIDTH{1'b0}};
      bmag_r   <= {WIDTH{1'b0}};
      result_r <= {WIDTH{1'b0}};
      is_rem_r <= 1'b0;
      neg_q_r  <= 1'b0;
      neg_r_r  <= 1'b0;
    end else if (load_s) begin
      cnt_r    <= {CNT_W{1'b0}};
      rem_r    <= {WIDTH{1'b0}};
      quo_r    <= a_mag_s;
      bmag_r   <= b_mag_s;
      is_rem_r <= is_rem_op(op_s);
      neg_q_r  <= sgn_s & (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
      neg_r_r  <= sgn_s & bus.A[WIDTH-1];
      if (special_s) begin
        result_r <= special_val_s;
      end
    end else if (iter_s) begin
      cnt_r <= cnt_r + CNT_W'(1);
      rem_r <= rem_next_s;
      quo_r <= quo_next_s;
      if (last_s) begin
        result_r <= final_s;
      end
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.busy      = busy_r;
  assign bus.out_valid = out_valid_r;
  assign bus.result    = result_r;
endmodule

// File: tb/tb_iter_divider.sv
// Self-checking bench for iter_divider: cycle-level reference model plus
// directed cases and randomized traffic with requests presented while busy.
module tb_iter_divider;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;

  iter_divider_if #(.WIDTH(32)) bus();

  iter_divider #(.WIDTH(32), .CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic logic is_special(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic sgn;
    sgn = (op == 2'd0) || (op == 2'd2);
    return (b == 32'd0) || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic sgn, rem;
    int   sa, sb;
    sgn = (op == 2'd0) || (op == 2'd2);
    rem = op[1];
    sa  = a;
    sb  = b;
    if (b == 32'd0) return rem ? a : 32'hFFFF_FFFF;
    if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return rem ? 32'd0 : 32'h8000_0000;
    if (sgn) return rem ? 32'(sa % sb) : 32'(sa / sb);
    return rem ? (a % b) : (a / b);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an accepted request keeps the unit busy for a fixed number of cycles.
  int          m_left   = 0;
  logic        m_valid  = 1'b0;
  logic [31:0] m_result = 32'd0;
  logic [31:0] m_pend   = 32'd0;
  logic        started  = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_left   <= 0;
      m_valid  <= 1'b0;
      m_result <= 32'd0;
      started  <= 1'b1;
    end else if (m_left > 0) begin
      m_left  <= m_left - 1;
      m_valid <= (m_left == 2);
      if (m_left == 2) m_result <= m_pend;
    end else if (bus.in_valid) begin
      if (is_special(bus.op, bus.A, bus.B)) begin
        m_left   <= 1;
        m_valid  <= 1'b1;
        m_result <= ref_div(bus.op, bus.A, bus.B);
      end else begin
        m_left  <= 33;
        m_valid <= 1'b0;
        m_pend  <= ref_div(bus.op, bus.A, bus.B);
      end
    end else begin
      m_valid <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("in_ready", {31'd0, bus.in_ready}, {31'd0, m_left == 0});
      chk("busy", {31'd0, bus.busy}, {31'd0, m_left != 0});
      chk("out_valid", {31'd0, bus.out_valid}, {31'd0, m_valid});
      chk("result", bus.result, m_result);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (m_left != 0 && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) chk("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic present(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.op       = op;
    bus.A        = a;
    bus.B        = b;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
  endtask

  // Waits for out_valid counting cycles from t0 and checks latency and result.
  task automatic await_result(input string name, input int t0, input int exp_t, input logic [31:0] exp);
    int t;
    t = t0;
    while (!bus.out_valid && t < 40) begin
      tick();
      t++;
    end
    chk({name, "_latency"}, t, exp_t);
    chk({name, "_result"}, bus.result, exp);
  endtask

  task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_t);
    wait_idle();
    present(op, a, b);
    await_result(name, 1, exp_t, exp);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int pulses;
    logic [1:0]  op;
    logic [31:0] a, b;

    bus.in_valid = 1'b0;
    bus.op       = 2'd0;
    bus.A        = 32'd0;
    bus.B        = 32'd0;
    repeat (2) tick();
    rst = 1'b0;

    chk("reset_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("reset_busy", {31'd0, bus.busy}, 32'd0);
    chk("reset_result", bus.result, 32'd0);

    chk("model_divu", ref_div(2'd1, 32'd100, 32'd7), 32'd14);
    chk("model_div_neg", ref_div(2'd0, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFD);
    chk("model_rem_neg", ref_div(2'd2, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);

    run_op("divu_100_7", 2'd1, 32'd100, 32'd7, 32'd14, 33);
    run_op("remu_100_7", 2'd3, 32'd100, 32'd7, 32'd2, 33);
    run_op("div_m7_2", 2'd0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
    run_op("rem_m7_2", 2'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
    run_op("rem_7_m2", 2'd2, 32'd7, 32'hFFFF_FFFE, 32'd1, 33);
    run_op("divu_5_0", 2'd1, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    run_op("remu_5_0", 2'd3, 32'd5, 32'd0, 32'd5, 1);
    run_op("div_m5_0", 2'd0, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 1);
    run_op("div_ovf", 2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_op("rem_ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);

    // A request while busy must be dropped, then accepted once re-presented in IDLE.
    wait_idle();
    present(2'd1, 32'd100, 32'd7);
    repeat (4) tick();
    present(2'd1, 32'd9, 32'd3);
    await_result("busy_drop", 6, 33, 32'd14);
    tick();
    chk("busy_drop_ready_t34", {31'd0, bus.in_ready}, 32'd1);
    chk("busy_drop_held", bus.result, 32'd14);
    run_op("represent_9_3", 2'd1, 32'd9, 32'd3, 32'd3, 33);

    // Reset mid-operation aborts without an output pulse.
    wait_idle();
    present(2'd1, 32'd1000, 32'd3);
    repeat (9) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("abort_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("abort_result", bus.result, 32'd0);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.out_valid) pulses++;
      tick();
    end
    chk("abort_no_pulse", pulses, 32'd0);
    run_op("divu_max_1", 2'd1, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 33);

    for (int n = 0; n < 250; n++) begin
      op = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0: a = $urandom_range(0, 1000);
        1: a = 32'h8000_0000;
        2: a = 32'd0 - $urandom_range(1, 1000);
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = 32'hFFFF_FFFF;
        2: b = $urandom_range(1, 20);
        3: b = 32'd0 - $urandom_range(1, 20);
        default: b = $urandom;
      endcase
      wait_idle();
      present(op, a, b);
      for (int k = 0; k < 40 && m_left != 0; k++) begin
        bus.in_valid = ($urandom_range(0, 3) == 0);
        bus.op       = 2'($urandom_range(0, 3));
        bus.A        = $urandom;
        bus.B        = $urandom;
        tick();
      end
      bus.in_valid = 1'b0;
      if ($urandom_range(0, 3) == 0) tick();
    end

    wait_idle();
    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
